// File: rtl/parking_pkg.sv
// Shared definitions for the parking slot sensor front-end: slot-state encodings
// and default parameter values (debounce defaults assume a 1 MHz clock).
package parking_pkg;

    localparam int NUM_SLOTS_DEF       = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 20000;  // 20 ms at 1 MHz
    localparam int CNT_W_DEF           = 15;
    localparam int CHATTER_LIMIT_DEF   = 8;

    typedef enum logic [1:0] {
        SLOT_EMPTY    = 2'd0,
        SLOT_ARRIVING = 2'd1,
        SLOT_OCCUPIED = 2'd2,
        SLOT_LEAVING  = 2'd3
    } slot_state_t;

endpackage

// File: rtl/slot_debouncer.sv
// One parking slot: 2-flop synchroniser, debounce FSM with counter, entry/exit pulses.
// Chatter fault detection is built only when PARKING_SENSOR_FAULT_EN is defined.
module slot_debouncer
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int CHATTER_LIMIT   = CHATTER_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic car_entry,
    output logic car_exit,
    output logic occupied,
    output logic occ_next,
    output logic fault
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             s;
    logic             done;
    slot_state_t      state;
    logic [CNT_W-1:0] cnt;

    assign s    = sync[1];
    assign done = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= 2'b00;
        else          sync <= {sync[0], raw};
    end

    // Occupancy the FSM will hold after this edge; the top builds free_count from it.
    always_comb begin
        occ_next = 1'b0;
        unique case (state)
            SLOT_EMPTY:    occ_next = 1'b0;
            SLOT_ARRIVING: occ_next = s & done;
            SLOT_OCCUPIED: occ_next = 1'b1;
            SLOT_LEAVING:  occ_next = s | ~done;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SLOT_EMPTY;
            cnt       <= '0;
            car_entry <= 1'b0;
            car_exit  <= 1'b0;
            occupied  <= 1'b0;
        end else begin
            car_entry <= 1'b0;
            car_exit  <= 1'b0;
            occupied  <= occ_next;
            unique case (state)
                SLOT_EMPTY: if (s) begin
                    state <= SLOT_ARRIVING;
                    cnt   <= '0;
                end
                SLOT_ARRIVING: begin
                    if (!s) state <= SLOT_EMPTY;
                    else if (done) begin
                        state     <= SLOT_OCCUPIED;
                        car_entry <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
                SLOT_OCCUPIED: if (!s) begin
                    state <= SLOT_LEAVING;
                    cnt   <= '0;
                end
                SLOT_LEAVING: begin
                    if (s) state <= SLOT_OCCUPIED;
                    else if (done) begin
                        state    <= SLOT_EMPTY;
                        car_exit <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
            endcase
        end
    end

`ifdef PARKING_SENSOR_FAULT_EN
    localparam int CH_W = $clog2(CHATTER_LIMIT + 1);

    logic [CH_W-1:0] chatter;
    logic            abort;
    logic            confirm;

    assign abort   = (state == SLOT_ARRIVING && !s) || (state == SLOT_LEAVING && s);
    assign confirm = done && ((state == SLOT_ARRIVING && s) || (state == SLOT_LEAVING && !s));

    // Consecutive aborted debounces; any confirmed change proves the sensor healthy again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chatter <= '0;
            fault   <= 1'b0;
        end else if (confirm) begin
            chatter <= '0;
        end else if (abort) begin
            if (chatter != CH_W'(CHATTER_LIMIT))     chatter <= chatter + 1'b1;
            if (chatter == CH_W'(CHATTER_LIMIT - 1)) fault   <= 1'b1;
        end
    end
`else
    // Never set: the limit only matters when chatter detection is built in.
    assign fault = (CHATTER_LIMIT < 0);
`endif

endmodule

// File: rtl/parking_slot_sensor.sv
// Parking sensor front-end: one slot_debouncer per slot plus the registered free-slot count.
// Optional chatter fault flags are enabled with PARKING_SENSOR_FAULT_EN.
module parking_slot_sensor
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS       = NUM_SLOTS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int CHATTER_LIMIT   = CHATTER_LIMIT_DEF
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_SLOTS-1:0]             sensor_raw,
    output logic [NUM_SLOTS-1:0]             car_entry,
    output logic [NUM_SLOTS-1:0]             car_exit,
    output logic [NUM_SLOTS-1:0]             occupied,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   free_count,
    output logic [NUM_SLOTS-1:0]             sensor_fault
);

    localparam int FC_W = $clog2(NUM_SLOTS + 1);

    logic [NUM_SLOTS-1:0] occ_next;
    logic [FC_W-1:0]      busy;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        slot_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .CHATTER_LIMIT   (CHATTER_LIMIT)
        ) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .raw       (sensor_raw[i]),
            .car_entry (car_entry[i]),
            .car_exit  (car_exit[i]),
            .occupied  (occupied[i]),
            .occ_next  (occ_next[i]),
            .fault     (sensor_fault[i])
        );
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_SLOTS; i++) busy = busy + FC_W'(occ_next[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) free_count <= FC_W'(NUM_SLOTS);
        else          free_count <= FC_W'(NUM_SLOTS) - busy;
    end

endmodule

// File: tb/tb_parking_slot_sensor.sv
// Bench for parking_slot_sensor: directed scenarios plus randomized sensor levels,
// checked every cycle against a run-length model of the debounce rules.
module tb_parking_slot_sensor;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int CW = 3;
    localparam int CL = 8;
    localparam int FW = 3;

`ifdef PARKING_SENSOR_FAULT_EN
    localparam int FAULT_ON = 1;
`else
    localparam int FAULT_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  sensor_raw = '0;
    logic [N-1:0]  car_entry, car_exit, occupied, sensor_fault;
    logic [FW-1:0] free_count;

    int checks = 0;
    int failures = 0;

    parking_slot_sensor #(
        .NUM_SLOTS       (N),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW),
        .CHATTER_LIMIT   (CL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sensor_raw   (sensor_raw),
        .car_entry    (car_entry),
        .car_exit     (car_exit),
        .occupied     (occupied),
        .free_count   (free_count),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;

    // Model: a slot's confirmed level flips once the synchronised input has
    // disagreed with it for D+1 consecutive edges; a shorter run is an abort.
    logic [N-1:0] r1 = '0, r2 = '0, lvl = '0;
    logic [N-1:0] m_entry = '0, m_exit = '0, m_fault = '0;
    int           run[N];
    int           aborts[N];
    int           entry_tot[N];
    int           exit_tot[N];
    int           m_free = N;

    initial begin
        for (int i = 0; i < N; i++) begin
            run[i] = 0; aborts[i] = 0; entry_tot[i] = 0; exit_tot[i] = 0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                r1 = '0; r2 = '0; lvl = '0; m_entry = '0; m_exit = '0; m_fault = '0;
                for (int i = 0; i < N; i++) begin run[i] = 0; aborts[i] = 0; end
            end else begin
                m_entry = '0;
                m_exit  = '0;
                for (int i = 0; i < N; i++) begin
                    if (r2[i] != lvl[i]) begin
                        run[i]++;
                        if (run[i] == D + 1) begin
                            lvl[i]    = r2[i];
                            run[i]    = 0;
                            aborts[i] = 0;
                            if (r2[i]) begin m_entry[i] = 1'b1; entry_tot[i]++; end
                            else       begin m_exit[i]  = 1'b1; exit_tot[i]++;  end
                        end
                    end else begin
                        if (run[i] > 0) aborts[i]++;
                        run[i] = 0;
                        if (FAULT_ON != 0 && aborts[i] >= CL) m_fault[i] = 1'b1;
                    end
                end
                r2 = r1;
                r1 = sensor_raw;
            end
            m_free = N - $countones(lvl);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison, settled 3 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            chk("car_entry",    int'(car_entry),    int'(m_entry));
            chk("car_exit",     int'(car_exit),     int'(m_exit));
            chk("occupied",     int'(occupied),     int'(lvl));
            chk("free_count",   int'(free_count),   m_free);
            chk("sensor_fault", int'(sensor_fault), int'(m_fault));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(3);
    endtask

    int snap, fexp;
    int hold[N];

    initial begin
        // 1: reset with all sensors high, then a fresh entry on every slot
        sensor_raw = 4'hF;
        cyc(3);
        chk("rst_free", int'(free_count), 4);
        chk("rst_occ", int'(occupied), 0);
        chk("rst_entry", int'(car_entry), 0);
        reset_n = 1'b1;
        cyc(6);
        chk("t1_early", int'(m_entry), 0);
        cyc(1);
        chk("t1_entry", int'(m_entry), 'hF);
        chk("t1_dut_entry", int'(car_entry), 'hF);
        chk("t1_free", m_free, 0);
        cyc(1);
        chk("t1_one_cycle", int'(m_entry), 0);

        // 2: clean arrival on slot 2 after a reset that discards occupancy
        sensor_raw = '0;
        do_reset();
        chk("t2_cleared", int'(lvl), 0);
        sensor_raw[2] = 1'b1;
        cyc(6);
        chk("t2_early", int'(m_entry), 0);
        cyc(1);
        chk("t2_entry", int'(m_entry), 'b0100);
        chk("t2_free", m_free, 3);
        cyc(1);
        chk("t2_one_cycle", int'(m_entry), 0);

        // 3: three-cycle glitch on slot 1
        snap = entry_tot[1];
        sensor_raw[1] = 1'b1;
        cyc(3);
        sensor_raw[1] = 1'b0;
        cyc(12);
        chk("t3_no_entry", entry_tot[1], snap);
        chk("t3_occ", int'(lvl), 'b0100);
        chk("t3_free", m_free, 3);

        // 4: bouncing departure on slot 0
        sensor_raw[0] = 1'b1;
        cyc(10);
        snap = exit_tot[0];
        sensor_raw[0] = 1'b0;
        cyc(2);
        sensor_raw[0] = 1'b1;
        cyc(1);
        sensor_raw[0] = 1'b0;
        cyc(6);
        chk("t4_early", int'(m_exit), 0);
        cyc(1);
        chk("t4_exit", int'(m_exit), 'b0001);
        cyc(8);
        chk("t4_once", exit_tot[0], snap + 1);

        // 5: slot 0 leaves while slot 3 arrives
        sensor_raw[0] = 1'b1;
        cyc(10);
        snap = m_free;
        sensor_raw[0] = 1'b0;
        sensor_raw[3] = 1'b1;
        cyc(7);
        chk("t5_exit", int'(m_exit), 'b0001);
        chk("t5_entry", int'(m_entry), 'b1000);
        chk("t5_free", m_free, snap);

        // 6: repeated aborted arrivals on slot 1
        sensor_raw = '0;
        do_reset();
        repeat (7) begin
            sensor_raw[1] = 1'b1; cyc(2);
            sensor_raw[1] = 1'b0; cyc(4);
        end
        chk("t6_below_limit", int'(m_fault), 0);
        sensor_raw[1] = 1'b1; cyc(2);
        sensor_raw[1] = 1'b0; cyc(4);
        fexp = (FAULT_ON != 0) ? 'b0010 : 0;
        chk("t6_fault", int'(m_fault), fexp);
        cyc(20);
        chk("t6_sticky", int'(m_fault), fexp);
        reset_n = 1'b0;
        cyc(1);
        chk("t6_reset_clr", int'(sensor_fault), 0);
        reset_n = 1'b1;
        cyc(2);

        // Random levels with hold times straddling the debounce length
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    sensor_raw[i] = ($urandom_range(0, 3) != 0) ? ~sensor_raw[i] : sensor_raw[i];
                    hold[i] = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 4) : $urandom_range(5, 14);
                end else hold[i]--;
            end
            if (c == 1500) reset_n = 1'b0;
            if (c == 1502) reset_n = 1'b1;
            cyc(1);
        end
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
